// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver control stage: default widths,
// the supported oversampling ratios, and the FSM state encoding.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  // Default geometry of a frame and of the counters.
  localparam int DATA_WIDTH_DEF     = 8;
  localparam int PRESCALE_WIDTH_DEF = 6;
  localparam int BIT_CNT_WIDTH_DEF  = 4;

  // Oversampling ratios the receiver is designed for.
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Binary-encoded receiver states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

endpackage : uart_rx_pkg

// File: rtl/edge_bit_counter.sv
// -----------------------------------------------------------------------------
// edge_bit_counter
// Counts oversampling clocks within a bit (edge_cnt) and bit positions within
// a frame (bit_cnt). Both counters are held at zero while enable is low.
//
// Ports:
//   clk       in   receiver clock
//   reset_n   in   asynchronous active-low reset
//   enable    in   1 = frame in progress, counters run
//   Prescale  in   oversampling ratio
//   edge_cnt  out  clock index within the current bit
//   bit_cnt   out  frame position
//   bit_end   out  last clock of the current bit
// -----------------------------------------------------------------------------
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int Prescale_width = PRESCALE_WIDTH_DEF,
  parameter int Bit_cnt_width  = BIT_CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [Prescale_width-1:0] Prescale,
  output logic [Prescale_width-1:0] edge_cnt,
  output logic [Bit_cnt_width-1:0]  bit_cnt,
  output logic                      bit_end
);

  localparam logic [Prescale_width-1:0] EDGE_ONE = Prescale_width'(1);
  localparam logic [Bit_cnt_width-1:0]  BIT_ONE  = Bit_cnt_width'(1);

  logic [Prescale_width-1:0] r_edge_cnt;
  logic [Bit_cnt_width-1:0]  r_bit_cnt;
  logic                      w_bit_end;

  // ">=" rather than "==" so a Prescale that shrinks mid-frame still
  // terminates the bit instead of letting edge_cnt run around.
  assign w_bit_end = (r_edge_cnt >= (Prescale - EDGE_ONE));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!enable) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_bit_end) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + BIT_ONE;
    end else begin
      r_edge_cnt <= r_edge_cnt + EDGE_ONE;
    end
  end

  assign edge_cnt = r_edge_cnt;
  assign bit_cnt  = r_bit_cnt;
  assign bit_end  = w_bit_end;

endmodule : edge_bit_counter

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// Control stage of the UART receiver. Walks START, DATA, optional PARITY and
// STOP against the oversampling clock, enables the sampler/checkers/
// deserializer, and pulses data_valid for one clock after a clean frame.
//
// Ports:
//   clk          in   receiver clock (Prescale x baud)
//   reset_n      in   asynchronous active-low reset
//   RX_IN        in   serial line, idle high
//   PAR_EN       in   1 = frame carries a parity bit
//   Prescale     in   oversampling ratio (8, 16 or 32)
//   strt_glitch  in   start checker: start bit sampled high
//   par_err      in   parity checker error
//   stp_err      in   stop checker error
//   edge_cnt     out  clock index within the current bit
//   bit_cnt      out  frame position (0 = start, 1..DATA_WIDTH = data, ...)
//   dat_samp_en  out  data sampler enable
//   strt_chk_en  out  start checker enable
//   par_chk_en   out  parity checker enable
//   stp_chk_en   out  stop checker enable
//   deser_en     out  deserializer shift strobe
//   data_valid   out  one-cycle frame-good pulse
// -----------------------------------------------------------------------------
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int Prescale_width = PRESCALE_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int Bit_cnt_width  = BIT_CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [Prescale_width-1:0] Prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [Prescale_width-1:0] edge_cnt,
  output logic [Bit_cnt_width-1:0]  bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      deser_en,
  output logic                      data_valid
);

  localparam logic [Bit_cnt_width-1:0] LAST_DATA_BIT = Bit_cnt_width'(DATA_WIDTH);

  state_e r_state;
  state_e w_next_state;
  logic   r_data_valid;
  logic   w_data_valid_next;
  logic   w_bit_end;
  logic   w_cnt_enable;

  assign w_cnt_enable = (r_state != IDLE);

  edge_bit_counter #(
    .Prescale_width (Prescale_width),
    .Bit_cnt_width  (Bit_cnt_width)
  ) u_edge_bit_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (w_cnt_enable),
    .Prescale (Prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (w_bit_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_data_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_data_valid <= w_data_valid_next;
    end
  end

  // Error flags are only looked at on bit_end; the checkers have settled
  // their registered results by then.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_next_state      = r_state;
    w_data_valid_next = 1'b0;
    strt_chk_en       = 1'b0;
    par_chk_en        = 1'b0;
    stp_chk_en        = 1'b0;
    deser_en          = 1'b0;
    dat_samp_en       = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (!RX_IN) w_next_state = START;
      end
      START: begin
        strt_chk_en = 1'b1;
        if (w_bit_end) w_next_state = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        // One shift strobe per data bit, on its last clock.
        deser_en = w_bit_end;
        if (w_bit_end && (bit_cnt == LAST_DATA_BIT))
          w_next_state = PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        par_chk_en = 1'b1;
        if (w_bit_end) w_next_state = par_err ? IDLE : STOP;
      end
      STOP: begin
        stp_chk_en = 1'b1;
        if (w_bit_end) begin
          w_next_state      = IDLE;
          w_data_valid_next = !stp_err;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign data_valid = r_data_valid;

endmodule : uart_rx_fsm

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
// Directed bench for uart_rx_fsm: a table of single-frame scenarios with
// hand-computed cycle positions (cycle 0 = first START cycle), plus a
// back-to-back / mid-frame reset sequence.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

  logic       clk;
  logic       reset_n;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       deser_en;
  logic       data_valid;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_fsm dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One single-frame scenario. Seq codes: 1=START 2=DATA 3=PARITY 4=STOP 0=IDLE.
  typedef struct {
    int         prescale;
    bit         par_en;
    bit         glitch;
    bit         par_err;
    bit         stp_err;
    logic [7:0] data;
    bit         stop_val;
    bit         rx_after;
    int         exp_idle;
    int         exp_deser;
    int         exp_first_deser;
    int         exp_last_deser;
    int         exp_valid_cyc;
    int         exp_max_stop_bit;
    int         exp_restart;
    bit         exp_par_seen;
    bit         exp_stp_seen;
    logic [19:0] exp_seq;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic rx_for(input vec_t v, input int cyc);
    int b;
    b = cyc / v.prescale;
    if (v.glitch)                      return (cyc < 2) ? 1'b0 : 1'b1;
    if (b == 0)                        return 1'b0;
    if (b <= 8)                        return v.data[b-1];
    if (v.par_en && b == 9)            return ^v.data;
    if (b == 9 + int'(v.par_en))       return v.stop_val;
    return v.rx_after;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_edge_cnt"},    int'(edge_cnt),    0);
    check({tag, "_bit_cnt"},     int'(bit_cnt),     0);
    check({tag, "_dat_samp_en"}, int'(dat_samp_en), 0);
    check({tag, "_strt_chk_en"}, int'(strt_chk_en), 0);
    check({tag, "_par_chk_en"},  int'(par_chk_en),  0);
    check({tag, "_stp_chk_en"},  int'(stp_chk_en),  0);
    check({tag, "_deser_en"},    int'(deser_en),    0);
    check({tag, "_data_valid"},  int'(data_valid),  0);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc, idle_cyc, deser_n, first_d, last_d, valid_cyc, valid_n;
    int max_sb, restart, edge_last, w;
    bit par_seen, stp_seen, started;
    logic [19:0] seq;
    logic [3:0]  prev, cur;
    string tag;
    tag = $sformatf("row%0d", idx);

    Prescale    = 6'(v.prescale);
    PAR_EN      = v.par_en;
    strt_glitch = v.glitch;
    par_err     = v.par_err;
    stp_err     = v.stp_err;
    RX_IN       = 1'b0;

    started = 1'b0;
    w = 0;
    while (w < 4 && !started) begin
      @(negedge clk);
      if (strt_chk_en) started = 1'b1;
      w++;
    end
    check({tag, "_start_entry"}, int'(started), 1);
    check({tag, "_edge0"}, int'(edge_cnt), 0);

    cyc = 0; idle_cyc = -1; deser_n = 0; first_d = -1; last_d = -1;
    valid_cyc = -1; valid_n = 0; max_sb = 0; restart = -1; edge_last = -1;
    par_seen = 1'b0; stp_seen = 1'b0; seq = 20'h1; prev = 4'd1;

    while (cyc < 600 && (idle_cyc < 0 || cyc < idle_cyc + 2)) begin
      if (deser_en) begin
        if (first_d < 0) first_d = cyc;
        last_d = cyc;
        deser_n++;
      end
      if (data_valid) begin
        valid_n++;
        valid_cyc = cyc;
      end
      if (cyc == v.prescale - 1) edge_last = int'(edge_cnt);
      if (idle_cyc < 0) begin
        cur = strt_chk_en ? 4'd1 : par_chk_en ? 4'd3 : stp_chk_en ? 4'd4 :
              dat_samp_en ? 4'd2 : 4'd0;
        if (cur != prev) seq = {seq[15:0], cur};
        prev = cur;
        if (par_chk_en) par_seen = 1'b1;
        if (stp_chk_en) begin
          stp_seen = 1'b1;
          if (int'(bit_cnt) > max_sb) max_sb = int'(bit_cnt);
        end
        if (!dat_samp_en) idle_cyc = cyc;
      end else if (strt_chk_en && restart < 0) begin
        restart = cyc;
      end
      RX_IN = rx_for(v, cyc);
      @(negedge clk);
      cyc++;
    end

    check({tag, "_edge_last"},  edge_last, v.prescale - 1);
    check({tag, "_idle_cyc"},   idle_cyc, v.exp_idle);
    check({tag, "_deser_n"},    deser_n, v.exp_deser);
    check({tag, "_first_deser"}, first_d, v.exp_first_deser);
    check({tag, "_last_deser"}, last_d, v.exp_last_deser);
    check({tag, "_valid_n"},    valid_n, (v.exp_valid_cyc >= 0) ? 1 : 0);
    check({tag, "_valid_cyc"},  valid_cyc, v.exp_valid_cyc);
    check({tag, "_max_stop_bit"}, max_sb, v.exp_max_stop_bit);
    check({tag, "_restart"},    restart, v.exp_restart);
    check({tag, "_par_seen"},   int'(par_seen), int'(v.exp_par_seen));
    check({tag, "_stp_seen"},   int'(stp_seen), int'(v.exp_stp_seen));
    check({tag, "_state_seq"},  int'(seq), int'(v.exp_seq));

    // Drain any re-entered frame with a quiet line and clean checkers.
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0; RX_IN = 1'b1;
    w = 0;
    while (w < 600 && dat_samp_en) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_drain_idle"}, int'(dat_samp_en), 0);
    repeat (2) @(negedge clk);
  endtask

  // Two clean frames with a 1-clock gap, then reset mid-DATA of a third.
  task automatic run_b2b();
    int cyc, pos, vn, v1, v2, w, busy;
    bit started;
    Prescale = 6'd8; PAR_EN = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    RX_IN = 1'b0;
    started = 1'b0;
    w = 0;
    while (w < 4 && !started) begin
      @(negedge clk);
      if (strt_chk_en) started = 1'b1;
      w++;
    end
    check("b2b_start_entry", int'(started), 1);

    cyc = 0; vn = 0; v1 = -1; v2 = -1;
    while (cyc < 192) begin
      if (data_valid) begin
        if (vn == 0) v1 = cyc;
        else if (vn == 1) v2 = cyc;
        vn++;
      end
      pos = cyc % 81;
      if (pos < 8)       RX_IN = 1'b0;
      else if (pos < 72) RX_IN = ((pos / 8) % 2 == 1);
      else if (pos < 80) RX_IN = 1'b1;
      else               RX_IN = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("b2b_valid_n", vn, 2);
    check("b2b_valid1_cyc", v1, 80);
    check("b2b_valid_gap", v2 - v1, 81);
    check("b2b_third_in_data", int'(dat_samp_en && !strt_chk_en && !stp_chk_en), 1);
    check("b2b_third_bit_cnt", int'(bit_cnt), 3);

    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    RX_IN = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (dat_samp_en || edge_cnt != 0 || bit_cnt != 0) busy++;
    end
    check("post_reset_idle", busy, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{prescale:8,  par_en:1, glitch:0, par_err:0, stp_err:0, data:8'hA5,
                stop_val:1, rx_after:1, exp_idle:88, exp_deser:8, exp_first_deser:15,
                exp_last_deser:71, exp_valid_cyc:88, exp_max_stop_bit:10, exp_restart:-1,
                exp_par_seen:1, exp_stp_seen:1, exp_seq:20'h12340};
    vecs[1] = '{prescale:16, par_en:0, glitch:0, par_err:0, stp_err:0, data:8'h3C,
                stop_val:1, rx_after:1, exp_idle:160, exp_deser:8, exp_first_deser:31,
                exp_last_deser:143, exp_valid_cyc:160, exp_max_stop_bit:9, exp_restart:-1,
                exp_par_seen:0, exp_stp_seen:1, exp_seq:20'h01240};
    vecs[2] = '{prescale:8,  par_en:0, glitch:1, par_err:0, stp_err:0, data:8'h00,
                stop_val:1, rx_after:1, exp_idle:8, exp_deser:0, exp_first_deser:-1,
                exp_last_deser:-1, exp_valid_cyc:-1, exp_max_stop_bit:0, exp_restart:-1,
                exp_par_seen:0, exp_stp_seen:0, exp_seq:20'h00010};
    vecs[3] = '{prescale:8,  par_en:1, glitch:0, par_err:1, stp_err:0, data:8'h5A,
                stop_val:1, rx_after:1, exp_idle:80, exp_deser:8, exp_first_deser:15,
                exp_last_deser:71, exp_valid_cyc:-1, exp_max_stop_bit:0, exp_restart:-1,
                exp_par_seen:1, exp_stp_seen:0, exp_seq:20'h01230};
    vecs[4] = '{prescale:8,  par_en:0, glitch:0, par_err:0, stp_err:1, data:8'hC3,
                stop_val:0, rx_after:0, exp_idle:80, exp_deser:8, exp_first_deser:15,
                exp_last_deser:71, exp_valid_cyc:-1, exp_max_stop_bit:9, exp_restart:81,
                exp_par_seen:0, exp_stp_seen:1, exp_seq:20'h01240};
    vecs[5] = '{prescale:32, par_en:1, glitch:0, par_err:0, stp_err:0, data:8'h81,
                stop_val:1, rx_after:1, exp_idle:352, exp_deser:8, exp_first_deser:63,
                exp_last_deser:287, exp_valid_cyc:352, exp_max_stop_bit:10, exp_restart:-1,
                exp_par_seen:1, exp_stp_seen:1, exp_seq:20'h12340};

    reset_n = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_line_high", int'(dat_samp_en), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    run_b2b();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_rx_fsm
